// File: rtl/demux_32_regbank.sv
// demux_32_regbank
//
// Write side of a 32-entry register bank. A valid/ready write is staged for one
// cycle (stage register plus registered one-hot decode of the target index) and
// committed on the following edge. A bulk-clear engine sweeps every entry to zero,
// one entry per cycle, while holding off new writes. All entries are exposed on a
// flat bus that feeds a 32:1 read mux directly.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   wr_valid   in   write request
//   wr_ready   out  write accepted on this edge when wr_valid && wr_ready
//   wr_select  in   target entry index
//   wr_data    in   write data
//   clr_start  in   single-cycle request to clear all entries
//   busy       out  high while the clear sweep runs
//   wr_onehot  out  decoded enable of the staged write, zero when nothing is staged
//   regs_out   out  entry i on bits [DATA_WIDTH*i +: DATA_WIDTH]

module demux_32_regbank #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       wr_valid,
   output logic                       wr_ready,
   input  logic [4:0]                 wr_select,
   input  logic [DATA_WIDTH-1:0]      wr_data,
   input  logic                       clr_start,
   output logic                       busy,
   output logic [31:0]                wr_onehot,
   output logic [32*DATA_WIDTH-1:0]   regs_out
);

   localparam int unsigned NumEntries = 32;

   typedef enum logic [0:0] {
      StIdle,
      StClear
   } state_e;

   state_e                  state_q;
   logic [4:0]              cnt_q;

   logic                    stage_valid_q;
   logic [4:0]              stage_sel_q;
   logic [DATA_WIDTH-1:0]   stage_data_q;
   logic [31:0]             onehot_q;
   logic [31:0]             onehot_d;

   logic [DATA_WIDTH-1:0]   regs_q [NumEntries];

   logic                    accept;

   // Clear wins over a write presented in the same cycle; the sender keeps holding.
   assign wr_ready = (state_q == StIdle) && !clr_start;
   assign accept   = wr_valid && wr_ready;
   assign busy     = (state_q == StClear);

   // Decode the incoming index now so the staged one-hot comes straight from a flop.
   always_comb begin
      onehot_d = '0;
      if (accept) begin
         onehot_d = 32'd1 << wr_select;
         if (ZERO_REG != 0) begin
            onehot_d[0] = 1'b0;
         end
      end
   end

   // Clear sequencer: cnt_q names the entry zeroed on the next edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 5'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (clr_start) begin
                  state_q <= StClear;
                  cnt_q   <= 5'd0;
               end
            end
            StClear: begin
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
               cnt_q   <= 5'd0;
            end
         endcase
      end
   end

   // Stage register: holds at most one accepted write for exactly one cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         stage_valid_q <= 1'b0;
         stage_sel_q   <= 5'd0;
         stage_data_q  <= '0;
         onehot_q      <= '0;
      end else begin
         stage_valid_q <= accept;
         onehot_q      <= onehot_d;
         if (accept) begin
            stage_sel_q  <= wr_select;
            stage_data_q <= wr_data;
         end
      end
   end

   assign wr_onehot = onehot_q;

   // Entry storage. The clear assignment comes last so it overrides a commit to the
   // same entry on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NumEntries; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NumEntries; i++) begin
            if (stage_valid_q && (stage_sel_q == 5'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
               regs_q[i] <= stage_data_q;
            end
            if ((state_q == StClear) && (cnt_q == 5'(i))) begin
               regs_q[i] <= '0;
            end
         end
      end
   end

   // Flatten for the read mux; entry 0 is tied off when it is the zero register.
   always_comb begin
      regs_out = '0;
      regs_out[0 +: DATA_WIDTH] = (ZERO_REG != 0) ? '0 : regs_q[0];
      for (int i = 1; i < NumEntries; i++) begin
         regs_out[DATA_WIDTH*i +: DATA_WIDTH] = regs_q[i];
      end
   end

endmodule

// File: tb/tb_demux_32_regbank.sv
module tb_demux_32_regbank;

   localparam int DW = 32;

   logic                clock = 1'b0;
   logic                reset;
   logic                wr_valid;
   logic                wr_ready;
   logic [4:0]          wr_select;
   logic [DW-1:0]       wr_data;
   logic                clr_start;
   logic                busy;
   logic [31:0]         wr_onehot;
   logic [32*DW-1:0]    regs_out;

   demux_32_regbank #(
      .DATA_WIDTH (DW),
      .ZERO_REG   (1)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_select (wr_select),
      .wr_data   (wr_data),
      .clr_start (clr_start),
      .busy      (busy),
      .wr_onehot (wr_onehot),
      .regs_out  (regs_out)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model: contents plus time-stamped events (edge counts).
   logic [DW-1:0] mem [32];
   bit            pend_v = 0;
   int            pend_sel = 0;
   logic [DW-1:0] pend_data = '0;
   int            cyc = 0;
   int            clr_edge = -1;
   logic [31:0]   exp_onehot = '0;
   bit            ready_seen;
   bit            exp_ready;

   // Busy spans the 32 cycles following the edge that sampled clr_start.
   function automatic bit m_busy();
      return (clr_edge >= 0) && (cyc >= clr_edge) && (cyc < clr_edge + 32);
   endfunction

   function automatic logic [32*DW-1:0] exp_vec();
      logic [32*DW-1:0] v;
      for (int i = 0; i < 32; i++) v[DW*i +: DW] = mem[i];
      return v;
   endfunction

   // One clock cycle of stimulus; the model advances alongside the DUT.
   task automatic step(input bit v, input int sel, input logic [DW-1:0] d,
                       input bit clr, input bit rst);
      bit acc;
      bit go;
      bit was_busy;
      reset     = rst;
      wr_valid  = v;
      wr_select = 5'(sel);
      wr_data   = d;
      clr_start = clr;
      #1;
      ready_seen = wr_ready;
      was_busy   = m_busy();
      exp_ready  = !was_busy && !clr;
      acc        = v && exp_ready && !rst;
      go         = clr && !was_busy && !rst;
      @(posedge clock);
      cyc++;
      if (rst) begin
         for (int i = 0; i < 32; i++) mem[i] = '0;
         pend_v     = 0;
         clr_edge   = -1;
         exp_onehot = '0;
      end else begin
         if (pend_v && pend_sel != 0) mem[pend_sel] = pend_data;
         if (was_busy) mem[cyc - clr_edge - 1] = '0;
         if (go) clr_edge = cyc;
         pend_v     = acc;
         pend_sel   = sel;
         pend_data  = d;
         exp_onehot = (acc && sel != 0) ? (32'd1 << sel) : 32'd0;
      end
      #1;
   endtask

   task automatic test_reset();
      step(0, 0, '0, 0, 1);
      step(0, 0, '0, 0, 1);
      checks++;
      if (regs_out !== '0) begin
         errors++; $display("FAIL reset_regs: got %h want 0", regs_out);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b want 0", busy);
      end
      checks++;
      if (wr_onehot !== 32'd0) begin
         errors++; $display("FAIL reset_onehot: got %h want 0", wr_onehot);
      end
      reset = 0; clr_start = 0; wr_valid = 0;
      #1;
      checks++;
      if (wr_ready !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b want 1", wr_ready);
      end
   endtask

   task automatic test_zero_entry();
      step(1, 0, 32'hFFFF_FFFF, 0, 0);
      checks++;
      if (ready_seen !== 1'b1) begin
         errors++; $display("FAIL zero_ready: got %b want 1", ready_seen);
      end
      checks++;
      if (wr_onehot !== 32'd0) begin
         errors++; $display("FAIL zero_onehot: got %h want 0", wr_onehot);
      end
      step(0, 0, '0, 0, 0);
      checks++;
      if (regs_out[0 +: DW] !== '0) begin
         errors++; $display("FAIL zero_entry0: got %h want 0", regs_out[0 +: DW]);
      end
      checks++;
      if (regs_out !== exp_vec()) begin
         errors++; $display("FAIL zero_regs: got %h want %h", regs_out, exp_vec());
      end
   endtask

   task automatic test_sweep();
      logic [DW-1:0] got;
      for (int i = 1; i < 32; i++) begin
         step(1, i, DW'(i), 0, 0);
         checks++;
         if (wr_onehot !== (32'd1 << i)) begin
            errors++; $display("FAIL sweep_onehot[%0d]: got %h want %h", i, wr_onehot, 32'd1 << i);
         end
      end
      step(0, 0, '0, 0, 0);
      // Read back through a 32:1 select, as the downstream mux would.
      for (int s = 0; s < 32; s++) begin
         got = regs_out[DW*s +: DW];
         checks++;
         if (got !== DW'(s)) begin
            errors++; $display("FAIL sweep_read[%0d]: got %h want %h", s, got, DW'(s));
         end
      end
   endtask

   task automatic test_clear();
      int busy_cycles = 0;
      int acc_idx = -1;
      for (int j = 0; j < 40 && acc_idx < 0; j++) begin
         step(1, 9, 32'h99, j == 0, 0);
         checks++;
         if (ready_seen !== exp_ready) begin
            errors++; $display("FAIL clear_ready[%0d]: got %b want %b", j, ready_seen, exp_ready);
         end
         checks++;
         if (busy !== m_busy()) begin
            errors++; $display("FAIL clear_busy[%0d]: got %b want %b", j, busy, m_busy());
         end
         checks++;
         if (regs_out !== exp_vec()) begin
            errors++; $display("FAIL clear_regs[%0d]: got %h want %h", j, regs_out, exp_vec());
         end
         if (j >= 1 && j <= 32) begin
            checks++;
            if (regs_out[DW*(j-1) +: DW] !== '0) begin
               errors++;
               $display("FAIL clear_entry[%0d]: got %h want 0", j - 1, regs_out[DW*(j-1) +: DW]);
            end
         end
         if (busy === 1'b1) busy_cycles++;
         if (wr_onehot === 32'h200) acc_idx = j;
      end
      checks++;
      if (busy_cycles != 32) begin
         errors++; $display("FAIL clear_busy_len: got %0d want 32", busy_cycles);
      end
      checks++;
      if (acc_idx != 33) begin
         errors++; $display("FAIL clear_held_accept: got cycle %0d want 33", acc_idx);
      end
      step(0, 0, '0, 0, 0);
      checks++;
      if (regs_out[DW*9 +: DW] !== 32'h99) begin
         errors++; $display("FAIL clear_held_commit: got %h want 99", regs_out[DW*9 +: DW]);
      end
   endtask

   task automatic test_simultaneous();
      bit done = 0;
      step(1, 5, 32'h55, 0, 0);
      step(0, 0, '0, 0, 0);
      step(1, 5, 32'hA5, 1, 0);
      checks++;
      if (wr_onehot !== 32'd0) begin
         errors++; $display("FAIL simul_not_accepted: got %h want 0", wr_onehot);
      end
      for (int j = 0; j < 40 && !done; j++) begin
         step(1, 5, 32'hA5, 0, 0);
         checks++;
         if (regs_out !== exp_vec()) begin
            errors++; $display("FAIL simul_regs[%0d]: got %h want %h", j, regs_out, exp_vec());
         end
         if (wr_onehot === 32'h20) done = 1;
      end
      checks++;
      if (!done) begin
         errors++; $display("FAIL simul_timeout: got no acceptance want acceptance");
      end
      checks++;
      if (regs_out[DW*5 +: DW] !== '0) begin
         errors++; $display("FAIL simul_cleared: got %h want 0", regs_out[DW*5 +: DW]);
      end
      step(0, 0, '0, 0, 0);
      checks++;
      if (regs_out[DW*5 +: DW] !== 32'hA5) begin
         errors++; $display("FAIL simul_commit: got %h want a5", regs_out[DW*5 +: DW]);
      end
   endtask

   task automatic test_reset_mid_clear();
      for (int i = 1; i < 32; i++) step(1, i, $urandom() | 32'h1, 0, 0);
      step(0, 0, '0, 0, 0);
      step(0, 0, '0, 1, 0);
      for (int j = 0; j < 10; j++) step(0, 0, '0, 0, 0);
      checks++;
      if (busy !== 1'b1 || regs_out !== exp_vec()) begin
         errors++; $display("FAIL midclr_pre: got busy=%b regs=%h want busy=1 regs=%h",
                            busy, regs_out, exp_vec());
      end
      checks++;
      if (regs_out[DW*10 +: DW] === '0 || regs_out[DW*31 +: DW] === '0) begin
         errors++; $display("FAIL midclr_uncleared: got zero want nonzero");
      end
      step(0, 0, '0, 0, 1);
      checks++;
      if (regs_out !== '0) begin
         errors++; $display("FAIL midclr_regs: got %h want 0", regs_out);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL midclr_busy: got %b want 0", busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] want [4];
      want[0] = 32'd1; want[1] = 32'd2; want[2] = 32'd3; want[3] = 32'd3;
      step(1, 7, 32'd1, 0, 0);
      for (int j = 0; j < 4; j++) begin
         if (j < 2) step(1, 7, DW'(j + 2), 0, 0);
         else step(0, 0, '0, 0, 0);
         checks++;
         if (regs_out[DW*7 +: DW] !== want[j]) begin
            errors++; $display("FAIL b2b[%0d]: got %h want %h", j, regs_out[DW*7 +: DW], want[j]);
         end
      end
   endtask

   task automatic test_random();
      bit v;
      bit clr;
      bit rst;
      int sel;
      logic [DW-1:0] d;
      for (int n = 0; n < 400; n++) begin
         v   = ($urandom() % 2) == 0;
         sel = int'($urandom() % 32);
         d   = $urandom();
         clr = ($urandom() % 40) == 0;
         rst = ($urandom() % 150) == 0;
         step(v, sel, d, clr, rst);
         if (!rst) begin
            checks++;
            if (ready_seen !== exp_ready) begin
               errors++; $display("FAIL rand_ready[%0d]: got %b want %b", n, ready_seen, exp_ready);
            end
         end
         checks++;
         if (busy !== m_busy()) begin
            errors++; $display("FAIL rand_busy[%0d]: got %b want %b", n, busy, m_busy());
         end
         checks++;
         if (wr_onehot !== exp_onehot) begin
            errors++; $display("FAIL rand_onehot[%0d]: got %h want %h", n, wr_onehot, exp_onehot);
         end
         checks++;
         if (regs_out !== exp_vec()) begin
            errors++; $display("FAIL rand_regs[%0d]: got %h want %h", n, regs_out, exp_vec());
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = '0;
      reset = 1; wr_valid = 0; wr_select = '0; wr_data = '0; clr_start = 0;
      test_reset();
      test_zero_entry();
      test_sweep();
      test_clear();
      test_simultaneous();
      test_reset_mid_clear();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/demux_32_regbank.md
# demux_32_regbank

Write-side counterpart of the 32:1 read mux: a 32-entry register bank written through a registered 5-to-32 select decode, with a valid/ready write port and a sequenced bulk-clear engine. All 32 entries are presented on a flat bus that feeds the `mux_32` inputs directly, so `mux_32` reads whatever this block last committed. It serves as the write port of register-file-style storage in the processor datapath.

## Interface

Parameters:

- DATA_WIDTH, 32, width of each entry.
- ZERO_REG, 1, when 1 entry 0 is hardwired to zero and writes to it are dropped.

Ports:

- clock  in  1  rising-edge clock; sole clock domain.
- reset  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted this edge when wr_valid && wr_ready.
- wr_select  in  5  target entry index.
- wr_data  in  DATA_WIDTH  write data.
- clr_start  in  1  single-cycle request to clear all entries.
- busy  out  1  high while the clear sequence runs.
- wr_onehot  out  32  decoded enable of the staged write; all-zero when nothing is staged.
- regs_out  out  32*DATA_WIDTH  entry i on bits [DATA_WIDTH*i +: DATA_WIDTH].

## Operation

**State machine.** Two states, IDLE and CLEAR, with a 5-bit clear counter `cnt`.

- IDLE → CLEAR on clr_start; `cnt` is loaded with 0.
- CLEAR: each edge writes 0 to entry `cnt`, then increments `cnt`.
- CLEAR → IDLE on the edge that clears entry 31.
- clr_start is ignored in CLEAR.
- busy = (state == CLEAR).

**Write port.**

- wr_ready = (state == IDLE) && !clr_start. This is combinational from state and clr_start.
- When clr_start and wr_valid arrive together in IDLE, the clear wins and the write is not accepted. The sender holds the request.

**Stage register.**

- An accepted write loads stage_valid=1, stage_sel, and stage_data.
- With no acceptance, stage_valid loads 0.
- wr_onehot = stage_valid ? (1 << stage_sel) : 0. When ZERO_REG=1, bit 0 is forced to 0.

**Commit.**

- On each edge with stage_valid=1, stage_data is written to entry stage_sel. The write is dropped if stage_sel==0 and ZERO_REG=1.
- Commit and clear on the same entry in the same edge: the clear wins.
- A staged write pending on entry to CLEAR commits normally. Entries k>0 are overwritten later by the sweep, so every entry reads 0 when busy falls.

**Entry 0.** When ZERO_REG=1, regs_out entry 0 is constant 0.

**Write ordering.** Writes commit in acceptance order. Back-to-back writes to the same entry: the last one wins.

**Reset.** Reset takes priority over everything and aborts a clear mid-sweep. It sets:

- all entries to 0;
- stage_valid=0, wr_onehot=0;
- state=IDLE, cnt=0, busy=0.

Because of the wr_ready rule, wr_ready=1 after reset while clr_start is low.

## Timing

- Write acceptance at edge N (wr_valid && wr_ready sampled high):
  - wr_onehot is valid between edges N and N+1.
  - The entry updates at edge N+1.
  - regs_out shows the new value after N+1.
- Write-to-regs_out latency is 2 edges; throughput is 1 write per cycle in IDLE.
- Clear sequence, with clr_start sampled at edge N:
  - busy rises after N and is high for exactly 32 cycles.
  - Entry k is cleared at edge N+1+k.
  - busy falls after edge N+32.
- wr_ready is 0 during every busy cycle and during the clr_start cycle.
- regs_out, busy, and wr_onehot come only from registers. wr_ready is the only output with a combinational dependence on an input (clr_start).

## Test plan

- **Reset and entry 0.** Assert reset for 2 cycles with ZERO_REG=1, then write 0xFFFFFFFF to entry 0. Required: all entries 0, busy=0, wr_ready=1, and wr_onehot=0 in the stage cycle. Entry 0 remains 0.
- **Sweep read-back.** Write value i to entry i for i=1..31 on consecutive cycles, then sweep `mux_32` select 0..31 on regs_out. Required: `mux_32` out equals select for every index. wr_onehot equals 1<<i exactly one cycle after each acceptance.
- **Clear sequence.** With entries holding i, pulse clr_start at edge N. Required: busy high for 32 cycles and entry k reads 0 after edge N+1+k. wr_ready=0 throughout, and held wr_valid is accepted on the first cycle after busy falls.
- **Simultaneous clr_start and write.** Raise clr_start and wr_valid (entry 5, 0xA5) together. Required: the write is not accepted and entry 5=0 at sequence end. The held write is then accepted and entry 5=0xA5 two edges later.
- **Reset mid-clear and back-to-back writes.** Assert reset at cnt=10 with entries 11..31 nonzero. Required: all entries 0, busy=0 after one edge. Then writes of 0x1, 0x2, 0x3 to entry 7 on consecutive cycles: entry 7 reads 1, 2, 3 on successive cycles and ends at 3.
